// File: rtl/mdu_iter.sv
// Iterative RV32M-style multiply/divide unit: one result bit per cycle,
// shift-add multiply and restoring divide sharing a single accumulator.
module mdu_iter #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data1,
  input  logic [NB_DATA-1:0] i_data2,
  input  logic               i_kill,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero
);

  localparam int NB_CNT = $clog2(NB_DATA) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NB_DATA-1:0] MIN_NEG  = {1'b1, {(NB_DATA-1){1'b0}}};
  localparam logic [NB_CNT-1:0]  LAST_CNT = NB_CNT'(NB_DATA - 1);

  logic [1:0]           state;
  logic [NB_CNT-1:0]    cnt;
  logic [2:0]           op_q;
  logic                 neg_q;
  logic [NB_DATA-1:0]   opnd;
  logic [2*NB_DATA-1:0] acc;

  logic [2:0]         op_in;
  logic               a_signed;
  logic               b_signed;
  logic               neg_a;
  logic               neg_b;
  logic               res_neg;
  logic               div_zero;
  logic               div_ovf;
  logic [NB_DATA-1:0] mag_a;
  logic [NB_DATA-1:0] mag_b;
  logic [NB_DATA-1:0] special_res;

  assign op_in = i_op[2:0];

  // REM takes the dividend's sign; MULHSU leaves B unsigned; unsigned ops never negate.
  always_comb begin
    a_signed    = (op_in == 3'b000) || (op_in == 3'b001) || (op_in == 3'b010) ||
                  (op_in == 3'b100) || (op_in == 3'b110);
    b_signed    = a_signed && (op_in != 3'b010);
    neg_a       = a_signed && i_data1[NB_DATA-1];
    neg_b       = b_signed && i_data2[NB_DATA-1];
    mag_a       = neg_a ? -i_data1 : i_data1;
    mag_b       = neg_b ? -i_data2 : i_data2;
    res_neg     = (op_in[2] && op_in[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero    = op_in[2] && (i_data2 == '0);
    div_ovf     = op_in[2] && !op_in[0] && (i_data1 == MIN_NEG) && (i_data2 == '1);
    special_res = div_zero ? (op_in[1] ? i_data1 : '1) : (op_in[1] ? '0 : i_data1);
  end

  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] mul_next;
  logic [NB_DATA:0]     div_shift;
  logic                 div_ge;
  logic [NB_DATA-1:0]   div_diff;
  logic [NB_DATA-1:0]   div_rem;
  logic [2*NB_DATA-1:0] div_next;
  logic [2*NB_DATA-1:0] acc_next;
  logic [2*NB_DATA-1:0] mul_fixed;
  logic [NB_DATA-1:0]   div_pick;
  logic [NB_DATA-1:0]   div_fixed;
  logic [NB_DATA-1:0]   calc_res;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[NB_DATA-1:1]};
    div_shift = {acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[NB_DATA-1:0] - opnd;
    div_rem   = div_ge ? div_diff : div_shift[NB_DATA-1:0];
    div_next  = {div_rem, acc[NB_DATA-2:0], div_ge};
    acc_next  = op_q[2] ? div_next : mul_next;
    mul_fixed = neg_q ? -acc_next : acc_next;
    div_pick  = op_q[1] ? acc_next[2*NB_DATA-1:NB_DATA] : acc_next[NB_DATA-1:0];
    div_fixed = neg_q ? -div_pick : div_pick;
    if (op_q[2])
      calc_res = div_fixed;
    else if (op_q[1:0] == 2'b00)
      calc_res = mul_fixed[NB_DATA-1:0];
    else
      calc_res = mul_fixed[2*NB_DATA-1:NB_DATA];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      o_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid && !i_kill) begin
            op_q  <= op_in;
            neg_q <= res_neg;
            if (div_zero || div_ovf) begin
              o_result <= special_res;
              state    <= ST_DONE;
            end else begin
              cnt   <= '0;
              opnd  <= op_in[2] ? mag_b : mag_a;
              acc   <= {{NB_DATA{1'b0}}, (op_in[2] ? mag_a : mag_b)};
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (i_kill) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + NB_CNT'(1);
            if (cnt == LAST_CNT) begin
              o_result <= calc_res;
              state    <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_DONE);
  assign o_zero  = (o_result == '0);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M corner cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_mdu_iter;

  localparam int N = 32;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic [2:0]    i_op    = '0;
  logic [N-1:0]  i_data1 = '0;
  logic [N-1:0]  i_data2 = '0;
  logic          i_kill  = 1'b0;
  logic          o_ready;
  logic          o_valid;
  logic [N-1:0]  o_result;
  logic          o_zero;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  mdu_iter #(.NB_DATA(N), .NB_OP(3)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_op    (i_op),
    .i_data1 (i_data1),
    .i_data2 (i_data2),
    .i_kill  (i_kill),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_result(o_result),
    .o_zero  (o_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    logic [31:0] r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return N + 1;
  endfunction

  // Reference model: tracks only "cycles until result" and the held result value.
  logic [31:0] m_hold = '0;
  logic [31:0] m_pend = '0;
  int          m_left = 0;
  bit          m_done = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_hold = '0;
      m_left = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (i_kill) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_hold = m_pend;
        end
      end
    end else if (i_valid && !i_kill) begin
      m_pend = ref_result(i_op, i_data1, i_data2);
      if (ref_latency(i_op, i_data1, i_data2) == 1) begin
        m_done = 1'b1;
        m_hold = m_pend;
      end else begin
        m_left = N;
      end
    end
  end

  always @(negedge i_clk) begin
    if (check_en) begin
      check_output("cyc_ready",  32'(o_ready),  32'(!m_done && m_left == 0));
      check_output("cyc_valid",  32'(o_valid),  32'(m_done));
      check_output("cyc_result", o_result,      m_hold);
      check_output("cyc_zero",   32'(o_zero),   32'(m_hold == 0));
    end
  end

  // Called on a falling edge; returns on the falling edge where the result is shown.
  task automatic apply_stimulus(input string name, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int exp_lat);
    int cyc;
    cyc = 0;
    while (!o_ready && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    if (!o_ready) begin
      check_output({name, "_ready_timeout"}, 32'(o_ready), 32'd1);
      return;
    end
    i_op    = op;
    i_data1 = a;
    i_data2 = b;
    i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data1 = $urandom;
    i_data2 = $urandom;
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    check_output({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_output({name, "_result"}, o_result, exp);
  endtask

  task automatic run_random(input string name, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    apply_stimulus(name, op, a, b, ref_result(op, a, b), ref_latency(op, a, b));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          mode;

    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    check_output("rst_ready",  32'(o_ready), 32'd1);
    check_output("rst_valid",  32'(o_valid), 32'd0);
    check_output("rst_result", o_result,     32'd0);
    check_output("rst_zero",   32'(o_zero),  32'd1);
    check_en = 1'b1;
    i_rst_n  = 1'b1;

    apply_stimulus("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    apply_stimulus("mulh_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    apply_stimulus("mulhu_max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    apply_stimulus("divu_zero", 3'd5, 32'h0000_1234,  32'h0,         32'hFFFF_FFFF, 1);
    apply_stimulus("remu_zero", 3'd7, 32'h0000_1234,  32'h0,         32'h0000_1234, 1);
    apply_stimulus("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    apply_stimulus("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    apply_stimulus("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // Kill in the 10th CALC cycle: result must stay at the previous value.
    @(negedge i_clk);
    i_op = 3'd5; i_data1 = 32'd100; i_data2 = 32'd7; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    check_output("kill_ready",  32'(o_ready), 32'd1);
    check_output("kill_valid",  32'(o_valid), 32'd0);
    check_output("kill_result", o_result,     32'hFFFF_FFFF);
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      check_output("kill_no_valid", 32'(o_valid), 32'd0);
    end

    // Kill while idle blocks a simultaneous request.
    i_op = 3'd0; i_data1 = 32'd3; i_data2 = 32'd5; i_valid = 1'b1; i_kill = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0; i_kill = 1'b0;
    check_output("idle_kill_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    check_output("idle_kill_ready2", 32'(o_ready), 32'd1);
    check_output("idle_kill_valid",  32'(o_valid), 32'd0);

    // Asynchronous reset in the 5th CALC cycle, then accept on the first edge after release.
    i_op = 3'd0; i_data1 = 32'd3; i_data2 = 32'd5; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check_output("arst_ready",  32'(o_ready), 32'd1);
    check_output("arst_valid",  32'(o_valid), 32'd0);
    check_output("arst_result", o_result,     32'd0);
    check_output("arst_zero",   32'(o_zero),  32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    apply_stimulus("post_rst_mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    for (int n = 0; n < 150; n++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = '0;
      else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (mode == 2) rb = 32'($urandom_range(1, 15));
      else if (mode == 3) ra = 32'($urandom_range(0, 3));
      run_random("rand", rop, ra, rb);
    end

    repeat (3) @(negedge i_clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, giving the operand/result width (any value ≥ 4).
REQ-002 The block SHALL have parameter NB_OP, default 3, giving the op code width.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_valid, input, 1 bit: request valid.
REQ-006 The block SHALL have port i_op, input, NB_OP bits: operation select.
REQ-007 The block SHALL have port i_data1, input, NB_DATA bits: operand A (multiplicand or dividend).
REQ-008 The block SHALL have port i_data2, input, NB_DATA bits: operand B (multiplier or divisor).
REQ-009 The block SHALL have port i_kill, input, 1 bit: synchronous abort of the in-flight operation.
REQ-010 The block SHALL have port o_ready, output, 1 bit: the block can accept a request.
REQ-011 The block SHALL have port o_valid, output, 1 bit: one-cycle result strobe.
REQ-012 The block SHALL have port o_result, output, NB_DATA bits: registered result.
REQ-013 The block SHALL have port o_zero, output, 1 bit: high when o_result == 0.

Function
REQ-014 The block SHALL encode i_op as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU (RV32M semantics).
REQ-015 The FSM SHALL have exactly three states, IDLE, CALC and DONE; o_ready = (state == IDLE).
REQ-016 The block SHALL accept a request at a rising edge where i_valid && o_ready, capturing i_op and both operands; i_valid is ignored outside IDLE.
REQ-017 On accept, signed ops SHALL convert operands to magnitudes and record the result sign: MUL*/DIV use signA^signB; REM uses signA; MULHSU treats B as unsigned.
REQ-018 CALC SHALL run exactly NB_DATA cycles under an iteration counter of width clog2(NB_DATA)+1, one bit per cycle: shift-add multiply into a 2*NB_DATA product, restoring divide producing NB_DATA quotient and remainder.
REQ-019 The CALC→DONE transition SHALL load o_result: MUL gives product[NB_DATA-1:0]; MULH/MULHSU/MULHU give product[2*NB_DATA-1:NB_DATA]; DIV/DIVU give quotient; REM/REMU give remainder; the sign correction (two's-complement negate, full 2*NB_DATA for multiply) is applied first.
REQ-020 For non-special ops, o_valid SHALL assert exactly NB_DATA+1 cycles after the accept edge, for one cycle (the DONE state), after which the FSM returns to IDLE.
REQ-021 Divide by zero SHALL bypass CALC (IDLE→DONE): DIV/DIVU give all-ones; REM/REMU give i_data1; o_valid asserts 1 cycle after accept.
REQ-022 Signed overflow (DIV/REM with A = 100..0, B = all-ones) SHALL bypass CALC: DIV gives A; REM gives 0; o_valid asserts 1 cycle after accept.
REQ-023 o_result SHALL hold its value until the next DONE load; o_zero SHALL be derived combinationally from o_result.
REQ-024 i_kill asserted in CALC or DONE SHALL force IDLE at the next edge, suppress or clear o_valid, and leave o_result unchanged.
REQ-025 i_kill in IDLE SHALL have no effect and SHALL block acceptance in that cycle if i_valid is also high.
REQ-026 o_ready SHALL be high in the DONE cycle+1 (the IDLE state), allowing back-to-back requests with one idle cycle minimum between result and next accept.

Reset
REQ-027 While i_rst_n = 0 (asynchronously) the block SHALL force state IDLE, counter 0, o_valid 0, o_result 0 (so o_zero 1) and o_ready 1, including mid-CALC.
REQ-028 After i_rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification (NB_DATA = 32)
REQ-029 The bench SHALL drive MUL with A = 7, B = 0xFFFFFFFD and require o_result = 0xFFFFFFEB with o_valid exactly 33 cycles after accept.
REQ-030 The bench SHALL drive MULH with A = B = 0x80000000 and require 0x40000000; MULHU with A = B = 0xFFFFFFFF and require 0xFFFFFFFE.
REQ-031 The bench SHALL drive DIVU with A = 0x1234, B = 0 and require 0xFFFFFFFF after 1 cycle; REMU with the same operands and require 0x00001234.
REQ-032 The bench SHALL drive DIV with A = 0x80000000, B = 0xFFFFFFFF and require 0x80000000 after 1 cycle; REM with A = 0xFFFFFFF9 (-7), B = 2 and require 0xFFFFFFFF.
REQ-033 The bench SHALL assert i_kill at CALC cycle 10 and require no o_valid, o_ready high next cycle, and o_result unchanged.
REQ-034 The bench SHALL assert i_rst_n = 0 at CALC cycle 5 and require immediate o_ready = 1, o_valid = 0, o_result = 0 and o_zero = 1.
